// File: rtl/cpu_prog_sequencer.sv
// Program sequencer for directed CPU bring-up: buffer, arm, start, issue, drain, check.
// Optional cycle counter output enabled by CPU_PROG_SEQ_CYCCNT_EN.
module cpu_prog_sequencer #(
    parameter int                 DATA_W       = 16,
    parameter int                 DEPTH        = 16,
    parameter int                 ADDR_W       = 4,
    parameter int                 START_DELAY  = 2,
    parameter int                 DRAIN_CYCLES = 4,
    parameter logic [DATA_W-1:0]  NOP_WORD     = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [DATA_W-1:0] obs_data,
`ifdef CPU_PROG_SEQ_CYCCNT_EN
    output logic [15:0]       cyc_cnt,
`endif
    output logic              enable,
    output logic              start,
    output logic [DATA_W-1:0] i_datain,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail
);

    typedef enum logic [2:0] {
        IDLE, ARM, START, ISSUE, DRAIN, CHECK, DONE
    } state_t;

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [15:0]       ARM_LAST = 16'(START_DELAY - 1);
    localparam logic [15:0]       DRN_LAST = 16'(DRAIN_CYCLES - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [ADDR_W:0]   len, len_n;
    logic [15:0]       cnt, cnt_n;
    logic [DATA_W-1:0] exp_q, exp_n, dat_n;
    logic              en_n, start_n, busy_n;
    logic              done_n, pass_n, fail_n;

    // Program buffer: writes land only while the sequencer is not running
    always_ff @(posedge clock) begin
        if (load_we && !busy)
            mem[load_addr] <= load_data;
    end

    // Next-state and next-output decode
    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_n   = len;
        cnt_n   = cnt;
        exp_n   = exp_q;
        en_n    = enable;
        start_n = 1'b0;
        dat_n   = NOP_WORD;
        done_n  = done;
        pass_n  = pass;
        fail_n  = fail;
        unique case (state)
            IDLE, DONE: begin
                if (go) begin
                    state_n = ARM;
                    len_n   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
                    exp_n   = exp_data;
                    cnt_n   = '0;
                    en_n    = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    fail_n  = 1'b0;
                end
            end
            ARM: begin
                if (cnt == ARM_LAST) begin
                    state_n = START;
                    start_n = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            START: begin
                if (len == '0) begin
                    state_n = DRAIN;
                end else begin
                    state_n = ISSUE;
                    idx_n   = '0;
                    dat_n   = mem[0];
                end
            end
            ISSUE: begin
                if ({1'b0, idx} == len - LEN_ONE) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    idx_n = idx + IDX_ONE;
                    dat_n = mem[idx + IDX_ONE];
                end
            end
            DRAIN: begin
                if (cnt == DRN_LAST)
                    state_n = CHECK;
                else
                    cnt_n = cnt + 16'd1;
            end
            CHECK: begin
                state_n = DONE;
                done_n  = 1'b1;
                pass_n  = (obs_data == exp_q);
                fail_n  = (obs_data != exp_q);
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE) && (state_n != DONE);
    end

    // State, run context and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            len      <= '0;
            cnt      <= '0;
            exp_q    <= '0;
            enable   <= 1'b0;
            start    <= 1'b0;
            i_datain <= NOP_WORD;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            len      <= len_n;
            cnt      <= cnt_n;
            exp_q    <= exp_n;
            enable   <= en_n;
            start    <= start_n;
            i_datain <= dat_n;
            busy     <= busy_n;
            done     <= done_n;
            pass     <= pass_n;
            fail     <= fail_n;
        end
    end

`ifdef CPU_PROG_SEQ_CYCCNT_EN
    logic go_acc;
    logic in_run;
    assign go_acc = go && ((state == IDLE) || (state == DONE));
    assign in_run = (state == START) || (state == ISSUE) ||
                    (state == DRAIN) || (state == CHECK);

    // Run length in cycles from START through CHECK, saturating
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cyc_cnt <= '0;
        else if (go_acc)
            cyc_cnt <= '0;
        else if (in_run && (cyc_cnt != 16'hFFFF))
            cyc_cnt <= cyc_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cpu_prog_sequencer.sv
// Self-checking bench for cpu_prog_sequencer: vector table, corner cases, random runs.
// Checks cyc_cnt as well when CPU_PROG_SEQ_CYCCNT_EN is defined.
module tb_cpu_prog_sequencer;

    localparam int          SD   = 2;
    localparam int          DC   = 4;
    localparam logic [15:0] NOP  = 16'h0000;
    localparam logic [15:0] SUBI = 16'h5122;
    localparam logic [15:0] HALT = 16'h0800;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        load_we = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic [4:0]  prog_len = '0;
    logic [15:0] exp_data = '0;
    logic [15:0] obs_data = '0;
    logic        enable, start, busy, done, pass, fail;
    logic [15:0] i_datain;
`ifdef CPU_PROG_SEQ_CYCCNT_EN
    logic [15:0] cyc_cnt;
`endif

    always #5 clock = ~clock;

    cpu_prog_sequencer #(
        .DATA_W(16), .DEPTH(16), .ADDR_W(4),
        .START_DELAY(SD), .DRAIN_CYCLES(DC), .NOP_WORD(NOP)
    ) dut (
        .clock(clock), .reset(reset), .go(go),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .prog_len(prog_len), .exp_data(exp_data), .obs_data(obs_data),
`ifdef CPU_PROG_SEQ_CYCCNT_EN
        .cyc_cnt(cyc_cnt),
`endif
        .enable(enable), .start(start), .i_datain(i_datain),
        .busy(busy), .done(done), .pass(pass), .fail(fail)
    );

    typedef struct {
        string       name;
        int          len;
        logic [15:0] e;
        logic [15:0] o;
        bit          want_pass;
    } vec_t;

    vec_t        tbl [6];
    logic [15:0] model_mem [16];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] outv();
        return {10'd0, enable, start, i_datain, busy, done, pass, fail};
    endfunction

    function automatic logic [31:0] mkv(bit en, bit st, logic [15:0] d,
                                        bit b, bit dn, bit p, bit f);
        return {10'd0, en, st, d, b, dn, p, f};
    endfunction

    task automatic wr(input int a, input logic [15:0] d);
        load_we   = 1'b1;
        load_addr = 4'(a);
        load_data = d;
        tick();
        load_we = 1'b0;
        model_mem[a] = d;
    endtask

    // One full run, every cycle compared against the expected trace
    task automatic run(input string name, input int len_in,
                       input logic [15:0] e, input logic [15:0] o,
                       input bit abuse, output bit got_pass);
        int L;
        int total;
        bit ex_start, ex_busy, ex_done;
        logic [15:0] ex_dat;
        L     = (len_in > 16) ? 16 : len_in;
        total = SD + 1 + L + DC + 1;
        got_pass = 1'b0;
        prog_len = 5'(len_in);
        exp_data = e;
        obs_data = o;
        go = 1'b1;
        tick();
        go = 1'b0;
        load_we = 1'b0;
        for (int k = 0; k <= total; k++) begin
            ex_start = (k == SD);
            ex_dat   = (k > SD && k <= SD + L) ? model_mem[k-SD-1] : NOP;
            ex_busy  = (k < total);
            ex_done  = (k == total);
            chk($sformatf("%s_k%0d", name, k), outv(),
                mkv(1'b1, ex_start, ex_dat, ex_busy, ex_done,
                    ex_done && (o == e), ex_done && (o != e)));
            if (k == total) begin
                got_pass = pass;
`ifdef CPU_PROG_SEQ_CYCCNT_EN
                chk({name, "_cyc"}, {16'd0, cyc_cnt}, 32'(2 + L + DC));
`endif
            end else begin
                if (abuse) begin
                    go        = 1'($urandom);
                    load_we   = 1'($urandom);
                    load_addr = 4'($urandom);
                    load_data = 16'($urandom);
                    exp_data  = 16'($urandom);
                end
                tick();
            end
        end
        go = 1'b0;
        load_we = 1'b0;
        exp_data = e;
    endtask

    initial begin
        bit          gp;
        int          ln;
        logic [15:0] e, o;

        tbl[0] = '{"subi_pass", 5, 16'h2200, 16'h2200, 1'b1};
        tbl[1] = '{"subi_miss", 5, 16'h2221, 16'h2200, 1'b0};
        tbl[2] = '{"len0", 0, 16'h0001, 16'h0001, 1'b1};
        tbl[3] = '{"len17", 17, 16'hBEEF, 16'hBEEF, 1'b1};
        tbl[4] = '{"len16", 16, 16'h1111, 16'h2222, 1'b0};
        tbl[5] = '{"len1", 1, 16'hFFFF, 16'hFFFF, 1'b1};

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        tick();
        chk("reset", outv(), mkv(0, 0, NOP, 0, 0, 0, 0));
`ifdef CPU_PROG_SEQ_CYCCNT_EN
        chk("reset_cyc", {16'd0, cyc_cnt}, 32'd0);
`endif

        for (int i = 0; i < 16; i++) wr(i, 16'($urandom));
        wr(0, SUBI);
        wr(1, NOP);
        wr(2, NOP);
        wr(3, NOP);
        wr(4, HALT);

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].name, tbl[i].len, tbl[i].e, tbl[i].o, 1'b0, gp);
            chk({tbl[i].name, "_pass"}, {31'd0, gp}, {31'd0, tbl[i].want_pass});
        end

        // Write in the same cycle as go: run must see the new word
        load_we   = 1'b1;
        load_addr = 4'd0;
        load_data = 16'hA5A5;
        model_mem[0] = 16'hA5A5;
        run("wr_with_go", 3, 16'h0042, 16'h0042, 1'b0, gp);

        // go and writes while busy are ignored
        run("abuse", 8, 16'h3333, 16'h3333, 1'b1, gp);
        run("after_abuse", 16, 16'h0, 16'h1, 1'b0, gp);

        // Asynchronous reset in the middle of ISSUE
        prog_len = 5'd5;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (SD + 3) tick();
        #2 reset = 1'b0;
        #1 chk("mid_reset", outv(), mkv(0, 0, NOP, 0, 0, 0, 0));
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        tick();
        chk("post_reset", outv(), mkv(0, 0, NOP, 0, 0, 0, 0));
        run("rerun", 5, 16'h1234, 16'h1234, 1'b0, gp);

        for (int r = 0; r < 25; r++) begin
            for (int w = 0; w < 3; w++)
                wr(int'($urandom_range(0, 15)), 16'($urandom));
            ln = int'($urandom_range(0, 20));
            e  = 16'($urandom);
            o  = ($urandom % 2 == 0) ? e : (e ^ 16'($urandom_range(1, 65535)));
            run($sformatf("rnd%0d", r), ln, e, o, 1'($urandom), gp);
            chk($sformatf("rnd%0d_pass", r), {31'd0, gp}, {31'd0, (o == e)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_prog_sequencer.md
Name: cpu_prog_sequencer

Overview:
- Synthesizable, parametrised program sequencer for directed CPU bring-up. Replaces per-instruction hand-written stimulus sequences.
- A program is preloaded into an internal word buffer. On a `go` request the block:
  - raises `enable` to the CPU,
  - issues a one-cycle `start` pulse,
  - streams the program onto the instruction bus one word per cycle,
  - drains with NOP words,
  - compares an observed CPU value against an expected value.
- Sits between bench/host control and the CPU's `enable`/`start`/`i_datain` inputs.

Parameters:
- DATA_W, 16, instruction and observe-data width.
- DEPTH, 16, program buffer depth in words.
- ADDR_W, 4, buffer address width; DEPTH must equal 2**ADDR_W.
- START_DELAY, 2, cycles `enable` is held high before the `start` pulse; must be ≥1.
- DRAIN_CYCLES, 4, NOP cycles after the last program word before checking; must be ≥1.
- NOP_WORD, 16'h0000, word driven whenever no program word is being issued.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  run request, sampled in IDLE only.
- load_we  in  1  program buffer write strobe.
- load_addr  in  ADDR_W  program buffer write address.
- load_data  in  DATA_W  program word to write.
- prog_len  in  ADDR_W+1  number of words to issue, sampled on go accept.
- exp_data  in  DATA_W  expected result, sampled on go accept.
- obs_data  in  DATA_W  observed CPU value (e.g. a GR or d_dataout).
- enable  out  1  CPU enable.
- start  out  1  CPU start pulse.
- i_datain  out  DATA_W  instruction word to CPU.
- busy  out  1  high in every state other than IDLE and DONE.
- done  out  1  run complete; held until the next go accept.
- pass  out  1  obs_data equalled exp_data at CHECK; held with done.
- fail  out  1  mismatch at CHECK; held with done.

Behaviour:
- Reset values:
  - enable=0, start=0, i_datain=NOP_WORD, busy=0, done=0, pass=0, fail=0.
  - State=IDLE; index and counters = 0.
  - Buffer contents are not reset.
- All outputs are registered.
- State machine:
  - IDLE:
    - `go` moves to ARM next cycle.
    - On accept, latch len=min(prog_len,DEPTH) and exp_data.
  - DONE: same as IDLE. `go` also clears done/pass/fail in the cycle it is accepted.
  - ARM:
    - enable=1, i_datain=NOP_WORD.
    - Lasts exactly START_DELAY cycles, then START.
  - START: start=1 for exactly one cycle, then ISSUE. If len=0, go to DRAIN instead.
  - ISSUE:
    - i_datain=buf[idx], idx counts 0..len-1, one word per cycle.
    - start=0 from the first ISSUE cycle.
    - After word len-1, go to DRAIN.
  - DRAIN: i_datain=NOP_WORD for DRAIN_CYCLES cycles, then CHECK.
  - CHECK:
    - One cycle; compares obs_data to the latched expected value.
    - Next cycle enters DONE with done=1 and exactly one of pass/fail set.
    - busy=0 in DONE.
- `enable` stays 1 from ARM until the next reset. Leaving DONE does not clear it.
- Latency, go accept to first program word on i_datain: START_DELAY+2 cycles.
- Buffer writes:
  - Accepted only when busy=0.
  - Ignored when busy=1; no error flag.
- load_we and go in the same IDLE cycle: the write lands, and the run sees the new word.
- go while busy: ignored.
- Reset asserted mid-run: all outputs go to their reset values immediately (asynchronous). Buffer contents are retained.
- prog_len > DEPTH: saturated to DEPTH words.

Optional Feature:
- Macro: CPU_PROG_SEQ_CYCCNT_EN.
- Defined:
  - Adds output `cyc_cnt` [15:0].
  - Cleared on go accept.
  - Increments once per cycle from the START cycle through CHECK inclusive.
  - Saturates at 16'hFFFF.
  - Holds in DONE.
  - Resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → all outputs at reset values; busy=0, done=0.
- Basic SUBI run:
  - Stimulus:
    - Load buf[0] = SUBI gr1,#0x22 encoding, buf[1..3] = NOP_WORD, buf[4] = HALT word.
    - prog_len=5, exp_data=16'h2200; obs_data tied to CPU gr[1], preset to 16'h2222.
    - Pulse go.
  - Response:
    - start high exactly once, START_DELAY+1 cycles after go.
    - buf[0]..buf[4] appear on consecutive cycles, then NOP_WORD.
    - done=1, pass=1, fail=0 after 1+START_DELAY+1+5+DRAIN_CYCLES+1 cycles.
- Mismatch: repeat with exp_data=16'h2221 → done=1, fail=1, pass=0.
- Boundaries:
  - prog_len=0 → no program words issued; DRAIN follows START directly.
  - prog_len=17 with DEPTH=16 → exactly 16 words issued, buf[15] last.
- Protocol abuse:
  - go and load_we pulsed during ISSUE → no restart; buffer unchanged.
  - Reset pulled low mid-ISSUE → outputs return to reset values within the same cycle; a new go then runs normally with the original buffer contents.
- Macro CPU_PROG_SEQ_CYCCNT_EN defined, basic run with START_DELAY=2, DRAIN_CYCLES=4, len=5 → cyc_cnt=11 (1 START + 5 ISSUE + 4 DRAIN + 1 CHECK) in DONE.
